// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, arbitrary depth,
// synchronous flush, occupancy output and optional first-word-fall-through read.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            wr_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C) && !full;
  assign almostempty = (count <= AE_C) && !empty;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_acc = rd_en && !empty && !clr;
  assign wr_acc = wr_en && (!full || rd_acc) && !clr;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown straight from storage; forced to zero while empty.
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (rd_acc) dout_q <= mem[rd_ptr];
        valid_q <= rd_acc;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = valid_q;
  end

endmodule
